fpu_issue_ctrl: RTL

//  Upstream issue stage for the single-precision fpu core (ADD/SUB/DIV/MUL).
//  - Buffers operand requests in a small FIFO and presents one op at a time on fpu_a/fpu_b/fpu_opcode.
//  - Holds those operands stable for a per-opcode multicycle latency, then captures fpu_o.
//  - Returns the result with its tag over a valid/ready handshake.
//  - Makes the deep combinational DIV/MUL paths safe multicycle paths.

---
 rtl/fpu_pkg.sv | 35 +++
 rtl/fpu_issue_ctrl_fifo.sv | 65 ++++++
 rtl/fpu_issue_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu issue stage: opcodes, FSM encoding, request record.
// Optional feature macro: FPU_FLAGS_EN (result class flags helper).
package fpu_pkg;

  localparam logic [1:0] FPU_OP_ADD = 2'b00;
  localparam logic [1:0] FPU_OP_SUB = 2'b01;
  localparam logic [1:0] FPU_OP_DIV = 2'b10;
  localparam logic [1:0] FPU_OP_MUL = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Tag width carried in the request record; the top's TAG_W must match it.
  localparam int FPU_TAG_W = 4;

  typedef struct packed {
    logic [31:0]          a;
    logic [31:0]          b;
    logic [1:0]           opcode;
    logic [FPU_TAG_W-1:0] tag;
  } fpu_req_t;

`ifdef FPU_FLAGS_EN
  // {nan, inf, zero} classification of an IEEE-754 single.
  function automatic logic [2:0] fpu_class(input logic [31:0] v);
    logic exp_ones, exp_zero, man_zero;
    exp_ones = (v[30:23] == 8'hFF);
    exp_zero = (v[30:23] == 8'h00);
    man_zero = (v[22:0] == 23'd0);
    return {exp_ones && !man_zero, exp_ones && man_zero, exp_zero && man_zero};
  endfunction
`endif

endpackage

// File: rtl/fpu_issue_ctrl_fifo.sv
// Request FIFO: DEPTH entries of fpu_req_t, synchronous push/pop, async reset.
module fpu_req_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fpu_req_t               push_data,
  input  logic                   pop,
  output fpu_req_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  fpu_req_t      mem_q [DEPTH];
  fpu_req_t      mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next-state: full blocks a push even when a pop happens the same cycle.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointers; power-of-2 pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue stage in front of the combinational fpu: queues requests, holds operands
// for a per-opcode latency (multicycle path), captures fpu_o and returns it with its tag.
// Optional feature macro: FPU_FLAGS_EN adds out_flags = {nan, inf, zero}.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = FPU_TAG_W,
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  input  logic [1:0]             in_opcode,
  input  logic [TAG_W-1:0]       in_tag,
  output logic [31:0]            fpu_a,
  output logic [31:0]            fpu_b,
  output logic [1:0]             fpu_opcode,
  input  logic [31:0]            fpu_o,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic [TAG_W-1:0]       out_tag,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef FPU_FLAGS_EN
  ,
  output logic [2:0]             out_flags
`endif
);

  localparam int LAT_MAX = (LAT_DIV > LAT_MUL) ? ((LAT_DIV > LAT_ADD) ? LAT_DIV : LAT_ADD)
                                               : ((LAT_MUL > LAT_ADD) ? LAT_MUL : LAT_ADD);
  localparam int CNT_W   = $clog2(LAT_MAX) + 1;

  // Hold count loaded on issue: capture happens when it reaches zero.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [1:0] op);
    case (op)
      FPU_OP_DIV: return CNT_W'(LAT_DIV - 1);
      FPU_OP_MUL: return CNT_W'(LAT_MUL - 1);
      default:    return CNT_W'(LAT_ADD - 1);
    endcase
  endfunction

  fpu_req_t         push_req, head;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
  logic [1:0]       fpu_op_q, fpu_op_d;
  logic [TAG_W-1:0] op_tag_q, op_tag_d, out_tag_q, out_tag_d;
  logic [31:0]      res_q, res_d;
  logic             out_valid_q, out_valid_d;
`ifdef FPU_FLAGS_EN
  logic [2:0]       flags_q, flags_d;
  assign out_flags = flags_q;
`endif

  assign in_ready   = !fifo_full;
  assign push_req   = '{a: in_a, b: in_b, opcode: in_opcode, tag: in_tag};
  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_opcode = fpu_op_q;
  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_tag    = out_tag_q;

  fpu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data (push_req),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Issue/wait/return FSM; fpu_* only move on a pop so the fpu inputs stay
  // stable for the whole hold window.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fpu_a_d     = fpu_a_q;
    fpu_b_d     = fpu_b_q;
    fpu_op_d    = fpu_op_q;
    op_tag_d    = op_tag_q;
    res_d       = res_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
`ifdef FPU_FLAGS_EN
    flags_d     = flags_q;
`endif
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: fifo_pop = !fifo_empty;
      ST_WAIT: begin
        if (cnt_q == '0) begin
          res_d       = fpu_o;
          out_tag_d   = op_tag_q;
          out_valid_d = 1'b1;
`ifdef FPU_FLAGS_EN
          flags_d     = fpu_class(fpu_o);
`endif
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fifo_pop    = !fifo_empty;
          if (fifo_empty) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fifo_pop) begin
      fpu_a_d  = head.a;
      fpu_b_d  = head.b;
      fpu_op_d = head.opcode;
      op_tag_d = head.tag;
      cnt_d    = lat_m1(head.opcode);
      state_d  = ST_WAIT;
    end
  end

  // FSM and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      fpu_op_q    <= '0;
      op_tag_q    <= '0;
      res_q       <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef FPU_FLAGS_EN
      flags_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      fpu_op_q    <= fpu_op_d;
      op_tag_q    <= op_tag_d;
      res_q       <= res_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
`ifdef FPU_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

endmodule
